uart_program_loader: RTL and testbench
======================================

Name: uart_program_loader

Overview:
- Sits between the UART receiver and the instruction memory write port.
- Packs received bytes into 32-bit instructions, MSB first, and writes them to consecutive memory addresses starting at 0.
- Stops on the halt word and reports done, or reports an error on memory overflow.
- Replaces ad-hoc byte packing with an explicit, armed load sequence.

Parameters:
- NB_DATA, 32, instruction width.
- N_BITS, 8, UART byte width.
- ADDR_W, 7, memory address width.
- MEM_DEPTH, 128, number of writable words.
- HALT_WORD, 32'hFFFF_FFFF, end-of-program marker.
- TIMEOUT_CYCLES, 3_000_000, inter-byte timeout (used only with LOADER_TIMEOUT_EN).

Ports:
- clock  in  1  system clock; the single clock domain.
- reset  in  1  synchronous, active-low reset.
- load_en_i  in  1  arms the loader; level-sensitive.
- rx_done_i  in  1  one-cycle pulse; rx_data_i is valid in that cycle.
- rx_data_i  in  N_BITS  received byte.
- wr_en_o  out  1  one-cycle memory write strobe.
- wr_addr_o  out  ADDR_W  write address.
- wr_data_o  out  NB_DATA  assembled instruction.
- loading_o  out  1  high in RECV and WRITE.
- done_o  out  1  halt word written.
- error_o  out  1  overflow or timeout.
- word_count_o  out  ADDR_W+1  number of words written in the current load.

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE; all outputs 0; byte counter, address counter and shift register cleared.
- IDLE:
  - Clears counters every cycle.
  - load_en_i==1 -> RECV.
  - rx_done_i is ignored.
- RECV, on rx_done_i:
  - shift <= {shift[23:0], rx_data_i}, so the first byte lands in [31:24].
  - byte_cnt increments, wrapping 3->0.
  - On the 4th byte, the assembled word is registered into wr_data_o and the state goes to WRITE.
- WRITE (exactly one cycle):
  - wr_en_o=1, wr_addr_o=addr_cnt; addr_cnt and word_count_o increment at the end of the cycle.
  - Latency: wr_en_o rises the cycle after the 4th rx_done_i.
  - Next state, in priority order:
    - word==HALT_WORD -> DONE. The halt word is still written, so the CPU fetches it.
    - addr_cnt==MEM_DEPTH-1 -> ERROR. The last slot is written, but no halt word has arrived.
    - Otherwise -> RECV.
  - An rx_done_i arriving during WRITE is captured as byte 0 of the next word (byte_cnt=1); bytes are never lost.
- DONE: done_o=1 and held. load_en_i==0 -> IDLE, which clears done_o and the counters; word_count_o holds until IDLE.
- ERROR: error_o=1 and held; no further writes. load_en_i==0 -> IDLE.
- load_en_i falls in RECV: -> IDLE next cycle; the partial word is discarded and no write occurs.
- load_en_i falls in WRITE: the write completes, then -> IDLE.
- Reset mid-operation: immediate return to the reset values; an in-flight wr_en_o is dropped at the next edge.
- Outputs are registered; wr_en_o is never asserted outside WRITE.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - A down-counter reloads to TIMEOUT_CYCLES on entry to RECV and on every rx_done_i.
  - If it reaches 0 in RECV -> ERROR; any partial word is discarded.
  - The counter does not run in IDLE, DONE or ERROR.
- Undefined: no counter is built; RECV waits indefinitely.

Decomposition:
- Shared package (loader_pkg):
  - state enum: IDLE, RECV, WRITE, DONE, ERROR;
  - HALT_WORD default;
  - byte-order constant (MSB-first);
  - width localparams derived from NB_DATA/N_BITS.
- One natural sub-module: word_assembler.
  - Contents: shift register plus byte counter.
  - Inputs: clock, reset, clear, rx_done_i/rx_data_i.
  - Outputs: word_valid pulse and word.
  - The FSM and address counter stay in the top.

Test Plan:
- Basic load: load_en_i=1; send bytes 20,08,00,05, 00,00,00,00, FF,FF,FF,FF -> three wr_en_o pulses:
  - addr 0 data 0x20080005;
  - addr 1 data 0x00000000;
  - addr 2 data 0xFFFFFFFF;
  - then done_o=1 and word_count_o=3.
- Back-to-back: rx_done_i on the cycle wr_en_o is high carries 0xAB -> the next written word has 0xAB in [31:24], with no byte loss.
- Abort: after 2 bytes, drop load_en_i -> no wr_en_o; IDLE next cycle; re-arm and send 4 bytes -> write at addr 0.
- Overflow: 128 non-halt words -> 128 writes at addr 0..127; error_o=1 after the write to addr 127; a further 4 bytes cause no write.
- Reset mid-word: reset=0 for one cycle after 3 bytes -> all outputs 0; the next 4 bytes form a clean word at addr 0.
- LOADER_TIMEOUT_EN with TIMEOUT_CYCLES=100: send 1 byte, then idle for 101 cycles -> error_o=1 and no write. With the macro undefined, the same stimulus keeps the loader in RECV with error_o=0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// Holds the loader state encoding, the default widths, the default halt word,
// the byte order used when packing bytes into a word, and a helper that
// derives the number of bytes per word.
package loader_pkg;

    localparam int          DEF_NB_DATA   = 32;
    localparam int          DEF_N_BITS    = 8;
    localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

    // First received byte ends up in the most significant byte of the word.
    localparam bit          MSB_FIRST     = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    function automatic int bytes_per_word(input int nb_data, input int n_bits);
        return nb_data / n_bits;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Byte-to-word packer for the UART program loader.
// Shifts incoming bytes into a word register and counts them. On the byte that
// completes a word, word_valid pulses combinationally in the same cycle and
// word carries the completed value, so the parent can register it on that edge.
// A synchronous clear discards any partial word.
module word_assembler
    import loader_pkg::*;
#(
    parameter int NB_DATA = DEF_NB_DATA,
    parameter int N_BITS  = DEF_N_BITS
)(
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               rx_done_i,
    input  logic [N_BITS-1:0]  rx_data_i,
    output logic               word_valid,
    output logic [NB_DATA-1:0] word
);

    localparam int              BYTES     = bytes_per_word(NB_DATA, N_BITS);
    localparam int              CNT_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

    logic [NB_DATA-1:0] r_shift;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic [NB_DATA-1:0] w_shift_next;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shift_next = {r_shift[NB_DATA-N_BITS-1:0], rx_data_i};
        end else begin : g_lsb_first
            assign w_shift_next = {rx_data_i, r_shift[NB_DATA-1:N_BITS]};
        end
    endgenerate

    // Shift register and byte counter; counter wraps after the last byte.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (clear) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (rx_done_i) begin
            r_shift    <= w_shift_next;
            r_byte_cnt <= (r_byte_cnt == LAST_BYTE) ? '0 : r_byte_cnt + 1'b1;
        end
    end

    assign word_valid = rx_done_i && !clear && (r_byte_cnt == LAST_BYTE);
    assign word       = w_shift_next;

endmodule

// File: rtl/uart_program_loader.sv
// UART program loader: packs UART bytes into instructions and writes them to
// consecutive instruction-memory addresses starting at 0, ending on the halt
// word (done) or on running out of memory (error).
// Optional build macro LOADER_TIMEOUT_EN adds an inter-byte timeout in RECV.
//
// state | meaning
// IDLE  | disarmed; counters held at zero
// RECV  | armed, collecting bytes of the current word
// WRITE | one-cycle memory write of the assembled word
// DONE  | halt word written; waits for load_en_i to drop
// ERROR | memory full without halt (or byte timeout); waits for load_en_i to drop
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int                 NB_DATA        = DEF_NB_DATA,
    parameter int                 N_BITS         = DEF_N_BITS,
    parameter int                 ADDR_W         = 7,
    parameter int                 MEM_DEPTH      = 128,
    parameter logic [NB_DATA-1:0] HALT_WORD      = DEF_HALT_WORD,
    parameter int                 TIMEOUT_CYCLES = 3_000_000
)(
    input  logic               clock,
    input  logic               reset,
    input  logic               load_en_i,
    input  logic               rx_done_i,
    input  logic [N_BITS-1:0]  rx_data_i,
    output logic               wr_en_o,
    output logic [ADDR_W-1:0]  wr_addr_o,
    output logic [NB_DATA-1:0] wr_data_o,
    output logic               loading_o,
    output logic               done_o,
    output logic               error_o,
    output logic [ADDR_W:0]    word_count_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    state_t             r_state;
    state_t             w_next_state;

    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_addr;
    logic [NB_DATA-1:0] r_wr_data;
    logic               r_loading;
    logic               r_done;
    logic               r_error;
    logic [ADDR_W:0]    r_word_count;

    logic               w_asm_clear;
    logic               w_word_valid;
    logic [NB_DATA-1:0] w_word;
    logic               w_timeout;

    // Bytes only accumulate while armed in RECV/WRITE; an abort or timeout in
    // RECV throws away the partial word in the same cycle.
    assign w_asm_clear = ((r_state != RECV) && (r_state != WRITE))
                      || ((r_state == RECV) && (!load_en_i || w_timeout));

    word_assembler #(
        .NB_DATA (NB_DATA),
        .N_BITS  (N_BITS)
    ) u_word_assembler (
        .clock      (clock),
        .reset      (reset),
        .clear      (w_asm_clear),
        .rx_done_i  (rx_done_i),
        .rx_data_i  (rx_data_i),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

`ifdef LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    assign w_timeout = (r_state == RECV) && (r_tmo_cnt == '0);

    // Inter-byte timer: reloads on entering RECV and on every byte, counts down only in RECV.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_tmo_cnt <= TMO_W'(TIMEOUT_CYCLES);
        end else if (((r_state != RECV) && (w_next_state == RECV))
                  || ((r_state == RECV) && rx_done_i)) begin
            r_tmo_cnt <= TMO_W'(TIMEOUT_CYCLES);
        end else if ((r_state == RECV) && (r_tmo_cnt != '0)) begin
            r_tmo_cnt <= r_tmo_cnt - 1'b1;
        end
    end
`else
    logic w_unused_tmo;

    assign w_timeout    = 1'b0;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode. In WRITE, halt wins over overflow so a halt in the
    // last slot still reports done; a dropped enable lets the write finish.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (load_en_i) w_next_state = RECV;
            end
            RECV: begin
                if (!load_en_i)        w_next_state = IDLE;
                else if (w_timeout)    w_next_state = ERROR;
                else if (w_word_valid) w_next_state = WRITE;
            end
            WRITE: begin
                if (r_wr_data == HALT_WORD) w_next_state = DONE;
                else if (r_addr == LAST_ADDR) w_next_state = ERROR;
                else if (!load_en_i)        w_next_state = IDLE;
                else                        w_next_state = RECV;
            end
            DONE: begin
                if (!load_en_i) w_next_state = IDLE;
            end
            ERROR: begin
                if (!load_en_i) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Registered outputs follow the state being entered, so each flag is
    // valid for exactly the cycles spent in its state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_en   <= 1'b0;
            r_loading <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_wr_data <= '0;
        end else begin
            r_wr_en   <= (w_next_state == WRITE);
            r_loading <= (w_next_state == RECV) || (w_next_state == WRITE);
            r_done    <= (w_next_state == DONE);
            r_error   <= (w_next_state == ERROR);
            if ((r_state == RECV) && (w_next_state == WRITE)) begin
                r_wr_data <= w_word;
            end
        end
    end

    // Address and word counters: cleared while idle, advanced after each write.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_addr       <= '0;
            r_word_count <= '0;
        end else if (r_state == IDLE) begin
            r_addr       <= '0;
            r_word_count <= '0;
        end else if (r_state == WRITE) begin
            r_addr       <= r_addr + 1'b1;
            r_word_count <= r_word_count + 1'b1;
        end
    end

    assign wr_en_o      = r_wr_en;
    assign wr_addr_o    = r_addr;
    assign wr_data_o    = r_wr_data;
    assign loading_o    = r_loading;
    assign done_o       = r_done;
    assign error_o      = r_error;
    assign word_count_o = r_word_count;

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader.
module tb_uart_program_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_en_i;
    logic        rx_done_i;
    logic [7:0]  rx_data_i;
    logic        wr_en_o;
    logic [6:0]  wr_addr_o;
    logic [31:0] wr_data_o;
    logic        loading_o;
    logic        done_o;
    logic        error_o;
    logic [7:0]  word_count_o;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: list of bytes of the current word, next address, flags.
    logic [7:0]  m_bytes[$];
    int          m_addr;
    bit          m_armed;
    bit          m_done;
    bit          m_err;
    logic [38:0] exp_q[$];
    logic [38:0] obs_q[$];

    uart_program_loader #(
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .load_en_i    (load_en_i),
        .rx_done_i    (rx_done_i),
        .rx_data_i    (rx_data_i),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .loading_o    (loading_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .word_count_o (word_count_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(negedge clock) begin
        if (wr_en_o === 1'b1) begin
            obs_q.push_back({wr_addr_o, wr_data_o});
            chk("wr_en_implies_loading", loading_o, 1);
        end
    end

    task tick;
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear;
        m_bytes.delete();
        m_addr  = 0;
        m_armed = 0;
        m_done  = 0;
        m_err   = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, output bit wrote,
                              output logic [6:0] a, output logic [31:0] w);
        wrote = 0;
        a     = '0;
        w     = '0;
        if (m_armed && !m_done && !m_err) begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 4) begin
                w     = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                a     = 7'(m_addr);
                wrote = 1;
                exp_q.push_back({a, w});
                m_addr++;
                m_bytes.delete();
                if (w == 32'hFFFF_FFFF) m_done = 1;
                else if (m_addr == 128) m_err = 1;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit          wrote;
        logic [6:0]  a;
        logic [31:0] w;
        model_byte(b, wrote, a, w);
        rx_data_i = b;
        rx_done_i = 1'b1;
        tick;
        rx_done_i = 1'b0;
        if (wrote) begin
            chk("wr_en_latency", wr_en_o, 1);
            chk("wr_addr", wr_addr_o, a);
            chk("wr_data", wr_data_o, w);
        end else begin
            chk("no_spurious_wr", wr_en_o, 0);
        end
        repeat (gap) tick;
    endtask

    task automatic send_word(input logic [31:0] w, input int last_gap);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[i*8 +: 8], (i == 0) ? last_gap : int'($urandom_range(0, 2)));
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom();
        if (w == 32'hFFFF_FFFF) w = 32'h0;
        return w;
    endfunction

    task automatic check_writes(input string tag);
        chk({tag, "_write_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk({tag, "_write"}, obs_q[i], exp_q[i]);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_done"}, done_o, m_done);
        chk({tag, "_error"}, error_o, m_err);
        chk({tag, "_word_count"}, word_count_o, m_addr);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr_en"}, wr_en_o, 0);
        chk({tag, "_wr_addr"}, wr_addr_o, 0);
        chk({tag, "_wr_data"}, wr_data_o, 0);
        chk({tag, "_loading"}, loading_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_error"}, error_o, 0);
        chk({tag, "_word_count"}, word_count_o, 0);
    endtask

    task automatic rearm;
        load_en_i = 1'b0;
        tick;
        model_clear();
        tick;
        load_en_i = 1'b1;
        m_armed   = 1;
        tick;
    endtask

    logic [7:0] basic_bytes [12];

    initial begin
        basic_bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00,
                        8'hFF, 8'hFF, 8'hFF, 8'hFF};
        reset     = 1'b0;
        load_en_i = 1'b0;
        rx_done_i = 1'b0;
        rx_data_i = 8'h00;
        model_clear();
        repeat (3) tick;
        check_all_zero("reset");

        // Idle ignores bytes.
        reset = 1'b1;
        tick;
        send_byte(8'h5A, 1);
        chk("idle_loading", loading_o, 0);
        check_status("idle");

        // Basic load ending in the halt word.
        load_en_i = 1'b1;
        m_armed   = 1;
        tick;
        chk("armed_loading", loading_o, 1);
        for (int i = 0; i < 12; i++) send_byte(basic_bytes[i], int'($urandom_range(0, 2)));
        tick;
        check_writes("basic");
        check_status("basic");
        chk("basic_loading_after_done", loading_o, 0);
        load_en_i = 1'b0;
        tick;
        model_clear();
        tick;
        check_status("idle_after_done");

        // Byte arriving during the WRITE cycle starts the next word.
        load_en_i = 1'b1;
        m_armed   = 1;
        tick;
        send_word(rand_word(), 0);
        send_byte(8'hAB, 0);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom()), int'($urandom_range(0, 2)));
        tick;
        if (obs_q.size() >= 2) chk("b2b_msb", obs_q[1][31:24], 8'hAB);
        check_writes("b2b");

        // Abort after two bytes, then re-arm.
        send_byte(8'($urandom()), 0);
        send_byte(8'($urandom()), 0);
        load_en_i = 1'b0;
        tick;
        chk("abort_loading", loading_o, 0);
        model_clear();
        tick;
        check_writes("abort");
        load_en_i = 1'b1;
        m_armed   = 1;
        tick;
        send_word(rand_word(), 1);
        tick;
        check_writes("rearm");

        // Reset in the middle of a word.
        for (int i = 0; i < 3; i++) send_byte(8'($urandom()), 0);
        reset = 1'b0;
        tick;
        check_all_zero("reset_mid");
        model_clear();
        m_armed = 1;
        reset   = 1'b1;
        tick;
        send_word(rand_word(), 1);
        tick;
        check_writes("reset_mid");

        // Overflow: fill all 128 slots with non-halt words.
        rearm();
        for (int k = 0; k < 128; k++) begin
            send_word(rand_word(), (k == 127) ? 0 : int'($urandom_range(0, 2)));
        end
        tick;
        check_status("overflow");
        chk("overflow_loading", loading_o, 0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom()), 1);
        tick;
        check_writes("overflow");
        check_status("overflow_after");

        // Long silence after one byte.
        rearm();
        send_byte(8'h11, 0);
`ifdef LOADER_TIMEOUT_EN
        begin
            int n;
            n = 0;
            while (error_o !== 1'b1 && n < 150) begin
                tick;
                n++;
            end
            chk("timeout_error", error_o, 1);
            chk("timeout_not_early", (n >= 100), 1);
            m_err = 1;
            m_bytes.delete();
        end
`else
        repeat (101) tick;
        chk("no_timeout_error", error_o, 0);
        chk("no_timeout_loading", loading_o, 1);
`endif
        tick;
        check_writes("timeout");
        check_status("timeout");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
